// File: rtl/celda_final_if.sv
// ----------------------------------------------------------------------------
// celda_final_if
//
// Bundles the signals that the last cell of the magnitude-comparator chain
// exchanges with its neighbours.
//
//   pout, qout : state code {p,q} from the preceding cell
//                01 = all higher bits equal, 10 = A > B decided,
//                11 = A < B decided, 00 = unused
//   A0, B0     : least-significant bit pair of words A and B
//   Zout       : registered network decision, 1 = A > B
//
// Timing: there is no valid/ready handshake on this bundle. The driver
// presents a new {pout,qout,A0,B0} sample every clock, and the cell takes it
// on every rising edge. Zout shows the decision for that sample one cycle
// after it is taken.
//
// Modports:
//   master : the side that drives the state code and bit pair and reads Zout
//   slave  : the comparator cell itself
// ----------------------------------------------------------------------------
interface celda_final_if;
    logic pout;
    logic qout;
    logic A0;
    logic B0;
    logic Zout;

    modport master (
        output pout,
        output qout,
        output A0,
        output B0,
        input  Zout
    );

    modport slave (
        input  pout,
        input  qout,
        input  A0,
        input  B0,
        output Zout
    );
endinterface

// File: rtl/celda_final.sv
// ----------------------------------------------------------------------------
// celda_final
//
// Final (least-significant) cell of an iterative magnitude comparator that
// scans words A and B from MSB to LSB. It combines the state code handed over
// by the preceding cell with the last bit pair and registers the single
// network decision.
//
// Ports:
//   clk   : system clock, rising-edge active
//   rst_n : asynchronous active-low reset, clears Zout
//   bus   : celda_final_if.slave
//           pout/qout in (state code), A0/B0 in (LSB pair),
//           Zout out (1 = A > B over the whole word)
//
// Latency is exactly one clock. There is no enable: a new sample is taken on
// every rising edge.
// ----------------------------------------------------------------------------
module celda_final (
    input  logic          clk,
    input  logic          rst_n,
    celda_final_if.slave  bus
);

    // Decoded state code coming from the preceding cell.
    typedef enum logic [1:0] {
        ST_ILLEGAL = 2'b00,
        ST_EQUAL   = 2'b01,  // state a: all higher bits equal so far
        ST_A_GT    = 2'b10,  // state b: A > B already decided
        ST_A_LT    = 2'b11   // state c: A < B already decided
    } cmp_state_t;

    cmp_state_t state_in;
    logic       d;
    logic       zout_q;

    assign state_in = cmp_state_t'({bus.pout, bus.qout});

    // Decision for the whole word. A decision already taken by the higher
    // bits dominates; only when they were all equal does the LSB pair decide.
    // The unused code 00 resolves to 0 so no X can reach the register.
    always_comb begin
        d = 1'b0;
        case (state_in)
            ST_EQUAL: d = bus.A0 & ~bus.B0;
            ST_A_GT:  d = 1'b1;
            ST_A_LT:  d = 1'b0;
            default:  d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zout_q <= 1'b0;
        end else begin
            zout_q <= d;
        end
    end

    assign bus.Zout = zout_q;

endmodule

// File: tb/tb_celda_final.sv
// ----------------------------------------------------------------------------
// tb_celda_final
//
// Directed bench for celda_final. Inputs change on the falling clock edge,
// Zout is sampled 1 ns after the rising edge (or mid-cycle for asynchronous
// reset and latency checks). Expected values are written by hand from the
// comparator truth table.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_celda_final;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    celda_final_if bus ();

    celda_final dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic p, input logic q, input logic a, input logic b);
        bus.pout = p;
        bus.qout = q;
        bus.A0   = a;
        bus.B0   = b;
    endtask

    // Apply one vector at the falling edge, check it after the next rising edge.
    task automatic step(input string tag, input logic p, input logic q,
                        input logic a, input logic b, input logic exp);
        @(negedge clk);
        drive(p, q, a, b);
        @(posedge clk);
        #1;
        check(tag, bus.Zout, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);   // state b

        // Reset asserted between edges: Zout must clear immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_immediate", bus.Zout, 1'b0);

        // Held low across several rising edges with state b present.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_held", bus.Zout, 1'b0);
        end

        // Release between edges: nothing changes until the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_pre_edge", bus.Zout, 1'b0);
        @(posedge clk);
        #1;
        check("rst_release_first_edge", bus.Zout, 1'b1);

        // State a (01): only A0B0 = 10 gives A > B.
        step("a_00", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("a_01", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("a_10", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("a_11", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // State b (10): decision already A > B.
        step("b_00", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("b_01", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step("b_10", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step("b_11", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

        // State c (11): decision already A < B.
        step("c_00", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("c_01", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("c_10", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("c_11", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Unused code 00: always 0, never X.
        step("ill_00", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ill_01", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("ill_10", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("ill_11", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Latency: move from state c to state b mid-cycle.
        step("lat_c", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("lat_before_edge", bus.Zout, 1'b0);
        @(posedge clk);
        #1;
        check("lat_after_edge", bus.Zout, 1'b1);

        // Short reset pulse between edges: drops Zout at once, the pending
        // value is discarded, and the next rising edge reloads the decision.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("pulse_async_drop", bus.Zout, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        check("pulse_held_until_edge", bus.Zout, 1'b0);
        @(posedge clk);
        #1;
        check("pulse_reload", bus.Zout, 1'b1);

        // Equal words after reset recovery: state a with A0 = B0.
        step("equal_words", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
